// File: rtl/clkdiv_pkg.sv
// Shared constants, divisor clamp and FSM state type for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MIN_DIV       = 2;
  localparam int unsigned CLKDIV_DEFAULT_WIDTH = 16;

  typedef enum logic {
    CLKDIV_IDLE = 1'b0,
    CLKDIV_RUN  = 1'b1
  } clkdiv_state_e;

  // Divisors below 2 cannot form a high and a low phase, so they run as 2.
  function automatic logic [31:0] clkdiv_clamp(input logic [31:0] div);
    return (div < 32'(CLKDIV_MIN_DIV)) ? 32'(CLKDIV_MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/clkdiv_shadow.sv
// Divisor shadow register: holds the active divisor and a pending reload that
// is committed only at a period boundary or when the divider stops.
module clkdiv_shadow
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = CLKDIV_DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic             div_load_i,
  input  logic             commit_i,
  input  logic             idle_i,
  output logic [WIDTH-1:0] div_act_o,
  output logic             pending_o
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(clkdiv_clamp(32'(DEFAULT_DIV)));

  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pending_q, pending_d;

  // A load that lands in IDLE or on the commit edge bypasses the shadow.
  always_comb begin
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pending_d  = pending_q;
    if (div_load_i && (idle_i || commit_i)) begin
      div_act_d = WIDTH'(clkdiv_clamp(32'(div_in_i)));
      pending_d = 1'b0;
    end else if (commit_i && pending_q) begin
      div_act_d = WIDTH'(clkdiv_clamp(32'(div_pend_q)));
      pending_d = 1'b0;
    end else if (div_load_i) begin
      div_pend_d = div_in_i;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act_q  <= RST_DIV;
      div_pend_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pending_q  <= pending_d;
    end
  end

  assign div_act_o = div_act_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free run-time divisor reload.
// Optional macro CLKDIV_TICK_EN builds the one-cycle tick pulse; otherwise tick is 0.
module clk_div_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = CLKDIV_DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             outclk,
  output logic             tick,
  output logic             pending
);

  clkdiv_state_e    state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH:0]   hi_act;
  logic             wrap_c;
  logic             commit_c;
  logic             idle_c;

  // Extra bit keeps an all-ones divisor from overflowing the +1.
  assign hi_act   = ({1'b0, div_act} + (WIDTH+1)'(1)) >> 1;
  assign idle_c   = (state_q == CLKDIV_IDLE);
  assign wrap_c   = (state_q == CLKDIV_RUN) && (cnt_q == div_act - WIDTH'(1));
  assign commit_c = (state_q == CLKDIV_RUN) && (!en || wrap_c);

  clkdiv_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_in_i   (div_in),
    .div_load_i (div_load),
    .commit_i   (commit_c),
    .idle_i     (idle_c),
    .div_act_o  (div_act),
    .pending_o  (pending)
  );

  // Next state and next count; outputs are derived from the next count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    outclk_d = 1'b0;
    case (state_q)
      CLKDIV_IDLE: begin
        if (en) state_d = CLKDIV_RUN;
      end
      CLKDIV_RUN: begin
        if (!en) state_d = CLKDIV_IDLE;
        else     cnt_d   = wrap_c ? '0 : cnt_q + WIDTH'(1);
      end
      default: state_d = CLKDIV_IDLE;
    endcase
    outclk_d = en && ({1'b0, cnt_d} < hi_act);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLKDIV_IDLE;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
    end
  end

  assign outclk = outclk_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  // Period start: entering RUN or wrapping, both of which give a zero next count.
  always_comb begin
    tick_d = en && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, parametrised clock divider: a successor to the fixed divide-by-2 toggle divider. It produces a registered divided clock `outclk` of any integer ratio 2..2^WIDTH-1 with near-50% duty and a one-cycle `tick` enable pulse per period. A new divisor can be loaded at run time and is committed glitch-free at the next period boundary. It sits between the board clock and slow peripherals (display refresh, debounce, single-step) in the RISC-V processor top level.

## Interface
- `WIDTH`, 16, divisor and counter width in bits; must be ≥ 2.
- `DEFAULT_DIV`, 2, divisor in effect after reset; clamped to a minimum of 2.
- `clk`  in  1  system clock; all logic is on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  run enable; when low, the divider idles.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  one-cycle strobe; captures `div_in`.
- `outclk`  out  1  registered divided clock.
- `tick`  out  1  one-cycle pulse on the cycle `outclk` rises.
- `pending`  out  1  a loaded divisor is waiting for the period boundary.

## Operation
- Effective divisor: `div_eff = max(div_x, 2)`. Values 0 and 1 are treated as 2.
- High length: `hi = (div_eff + 1) >> 1`, computed in WIDTH+1 bits so that an all-ones divisor does not overflow.
  - `outclk` is high for `hi` cycles and low for `div_eff - hi` cycles.
  - Examples: div=2 gives 1,0; div=3 gives 1,1,0; div=5 gives 1,1,1,0,0.
- States:
  - IDLE: `cnt = 0`, `outclk = 0`, `tick = 0`.
  - RUN: `cnt` counts 0 .. `div_act - 1`, then wraps to 0.
- Transitions:
  - IDLE → RUN when `en` is sampled high. The next edge sets `cnt = 0`, `outclk = 1`, `tick = 1`.
  - RUN → IDLE when `en` is sampled low. The next edge sets IDLE values immediately, mid-period. No completion of the current period.
- Registered outputs are computed from the next count value:
  - `outclk <= (cnt_next < hi_act)`.
  - `tick <= (cnt_next == 0)` in RUN.
- Divisor shadowing:
  - `div_load` in IDLE: `div_act <= div_in` immediately; `pending` stays 0.
  - `div_load` in RUN: `div_pend <= div_in`, `pending <= 1`.
  - On the wrap edge (`cnt == div_act - 1`), if `pending`: `div_act <= div_pend`, `pending <= 0`.
  - `div_load` coincident with a wrap: `div_in` is committed directly on that edge; `pending` stays 0.
  - Multiple loads before the boundary: the last one wins.
  - `en` falling with `pending = 1`: `div_pend` is committed on the RUN→IDLE edge.
- A period in progress always completes with the old divisor. There are no runt or stretched pulses while `en` stays high.

## Timing
- Reset values (async assert, any time): `cnt = 0`, `div_act = clamp(DEFAULT_DIV)`, `div_pend = 0`, `pending = 0`, `outclk = 0`, `tick = 0`, state IDLE.
- Reset deassertion is sampled at the next posedge. Reset mid-period aborts the period cleanly.
- Latency from `en` sampled high to `outclk` high: 1 cycle.
- Period is exactly `div_eff` clk cycles. `tick` is high on exactly 1 cycle per period, coincident with the rising `outclk`.
- All outputs are flops with no combinational path from inputs, so `outclk` is glitch-free.
- `pending` rises 1 cycle after `div_load` and falls on the wrap edge.

## Configuration
- `CLKDIV_TICK_EN` defined: the `tick` logic is built as specified.
- Undefined: `tick` is tied to 0 and its flop is not built. All other behaviour is identical.

## Structure
- Package `clkdiv_pkg` holds:
  - constants `CLKDIV_MIN_DIV = 2` and `CLKDIV_DEFAULT_WIDTH = 16`;
  - function `clkdiv_clamp(div)`, which returns `max(div, 2)`;
  - the state enum `{CLKDIV_IDLE, CLKDIV_RUN}`.
- Sub-module `clkdiv_shadow`: owns `div_act`, `div_pend` and `pending`. Inputs are `div_in`, `div_load`, `commit` (wrap or RUN→IDLE) and `idle`. The top level holds the FSM, counter and output flops.

## Test plan
- Reset with DEFAULT_DIV=2, then `en=1` → `outclk` 0 until 1 cycle after `en`, then 1,0,1,0…; `tick` high every 2nd cycle, on the high cycles.
- Load div=5 in IDLE, then `en=1` → `outclk` pattern 1,1,1,0,0 repeating; `pending` stays 0.
- Running div=4, load 7 at cnt=1 → `pending=1` next cycle; current period finishes as 4 cycles (1,1,0,0); next period is 7 cycles (1,1,1,1,0,0,0); `pending=0` after the wrap.
- Load 0 and 1 → behaves as div=2. Load all-ones with WIDTH=4 (div=15) → 8 high / 7 low, no overflow.
- Drop `en` mid-high phase → `outclk=0` and `tick=0` the next cycle. Re-raise `en` → a fresh period starts with `tick=1`.
- Assert `rst_n=0` asynchronously mid-period → `outclk`, `tick` and `pending` go 0 without waiting for a clock edge. Build without `CLKDIV_TICK_EN` → `tick` is constantly 0.
